cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
- Consumes the one-cycle pulses produced by the button debouncers and generates the CPU clock-enable (cpu_en).
- Supports single-step, N-instruction burst, free-run, and a PC breakpoint halt.
- Sits between the debounced board buttons and the CPU core.
- Also keeps a retired-cycle counter for the on-board display.

Parameters:
CNT_W, 32, width of step_cnt counter
BURST_W, 8, width of burst_len and internal remaining-step counter
PC_W, 32, width of pc and bp_addr

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
step_pulse  input  1  debounced one-cycle pulse: execute one instruction
run_pulse  input  1  debounced one-cycle pulse: toggle run/pause
burst_pulse  input  1  debounced one-cycle pulse: execute burst_len instructions
burst_len  input  BURST_W  burst length, sampled on accepted burst_pulse
pc  input  PC_W  PC of instruction the CPU executes on next cpu_en cycle
bp_addr  input  PC_W  breakpoint address
bp_en  input  1  breakpoint enable
cnt_clr  input  1  synchronous clear of step_cnt
cpu_en  output  1  CPU advances one instruction on each clk edge where high
state  output  2  0=PAUSE 1=RUN 2=BURST 3=BP_HALT
bp_hit  output  1  high while in BP_HALT
step_cnt  output  CNT_W  count of cpu_en-high cycles

Behaviour:
- Reset (rstn low, async): state=PAUSE, step_q=0, remaining=0, skip=0, step_cnt=0. Consequently cpu_en=0 and bp_hit=0.
- bp_match = bp_en & (pc == bp_addr), combinational.
- step_q: register loaded with an accepted step_pulse. Step is accepted only in PAUSE or BP_HALT, and only when no run_pulse/burst_pulse is accepted in the same cycle.
- cpu_en is combinational:
  - PAUSE/BP_HALT: cpu_en = step_q. Breakpoint is ignored, so a step can leave a breakpoint.
  - RUN/BURST: cpu_en = ~bp_match | skip.
- Latency: step_pulse at edge k gives cpu_en high for exactly the cycle after k (one cycle only).
- Input priority in the same cycle: run_pulse > burst_pulse > step_pulse. Lower-priority pulses are dropped, not queued.
- PAUSE:
  - run_pulse -> RUN, skip=0.
  - burst_pulse with burst_len!=0 -> BURST, remaining=burst_len, skip=0.
  - burst_pulse with burst_len==0 is ignored; state stays PAUSE and no step is taken.
- RUN:
  - run_pulse -> PAUSE; cpu_en low from the next cycle.
  - bp_match & ~skip -> BP_HALT; cpu_en is already low in the matching cycle.
  - step_pulse/burst_pulse ignored.
  - skip clears after the first cpu_en cycle.
- BURST:
  - On each cpu_en cycle, remaining decrements.
  - If remaining==1 on a cpu_en cycle -> PAUSE, remaining=0.
  - run_pulse aborts -> PAUSE, remaining=0.
  - bp_match & ~skip -> BP_HALT, remaining=0.
  - step_pulse ignored; burst_pulse ignored (no reload).
- BP_HALT:
  - run_pulse -> RUN with skip=1, so the breakpoint instruction executes once.
  - burst_pulse with burst_len!=0 -> BURST with skip=1.
  - step_pulse -> one-cycle step; state stays BP_HALT.
  - Changing bp_en or bp_addr does not leave BP_HALT.
- skip: set on entering RUN/BURST from BP_HALT; cleared on the first cpu_en cycle.
- step_cnt:
  - +1 on every cycle with cpu_en=1; wraps from all-ones to 0.
  - cnt_clr has priority over increment, so clear and increment in the same cycle gives 0.
- Async reset mid-burst or mid-run: immediate return to PAUSE, cpu_en=0 with no glitch step after release.

Test Plan:
- Reset, then step_pulse 1 cycle at t=10 -> cpu_en high exactly at cycle 11, state=0, step_cnt=1; three more steps -> step_cnt=4.
- burst_len=5, burst_pulse -> state=2, cpu_en high 5 consecutive cycles, then state=0, step_cnt=+5. burst_len=0, burst_pulse -> no change.
- run_pulse, bp_en=1, bp_addr=0x40, pc incrementing by 4 from 0x0 each cpu_en cycle -> cpu_en low at pc=0x40, state=3, bp_hit=1, step_cnt=16. Then run_pulse -> pc 0x40 executes, run continues past 0x44.
- burst_len=10; run_pulse at the 4th burst cycle -> state=0 next cycle, exactly 4 (or 3 if aborted before that cycle's enable) steps counted; verify remaining is not reused on the next burst.
- Same-cycle run_pulse+step_pulse in PAUSE -> RUN, no separate step; cnt_clr with cpu_en=1 -> step_cnt=0; step_cnt preload near 2^CNT_W-1 via long run -> wraps to 0.
- Deassert rstn asynchronously mid-RUN -> cpu_en=0, state=0, step_cnt=0 immediately; release -> remains PAUSE.

Source files
------------

// File: rtl/cpu_step_ctrl_if.sv
// Board-side bundle for cpu_step_ctrl: debounced button pulses, breakpoint setup,
// PC feedback from the core, and the clock-enable/status outputs.
interface cpu_step_ctrl_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned PC_W    = 32
);
    logic               step_pulse;
    logic               run_pulse;
    logic               burst_pulse;
    logic [BURST_W-1:0] burst_len;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    bp_addr;
    logic               bp_en;
    logic               cnt_clr;
    logic               cpu_en;
    logic [1:0]         state;
    logic               bp_hit;
    logic [CNT_W-1:0]   step_cnt;

    // Buttons, core PC and breakpoint setup drive the controller.
    modport master (
        output step_pulse, run_pulse, burst_pulse, burst_len,
        output pc, bp_addr, bp_en, cnt_clr,
        input  cpu_en, state, bp_hit, step_cnt
    );

    // The step controller itself.
    modport slave (
        input  step_pulse, run_pulse, burst_pulse, burst_len,
        input  pc, bp_addr, bp_en, cnt_clr,
        output cpu_en, state, bp_hit, step_cnt
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: single-step, N-instruction burst, free-run and
// PC breakpoint halt, plus a count of cycles in which the CPU advanced.
module cpu_step_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned PC_W    = 32
) (
    input logic             clk,
    input logic             rstn,
    cpu_step_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StPause  = 2'd0,
        StRun    = 2'd1,
        StBurst  = 2'd2,
        StBpHalt = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               step_q, step_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    // Lets the instruction sitting on the breakpoint execute once after resuming.
    logic               skip_q, skip_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    bp_addr;
    logic               bp_match;
    logic               halted;
    logic               burst_ok;
    logic               cpu_en;

    assign pc       = bus.pc;
    assign bp_addr  = bus.bp_addr;
    assign bp_match = bus.bp_en & (pc == bp_addr);
    assign halted   = (state_q == StPause) | (state_q == StBpHalt);
    // A zero-length burst request is treated as if the button was never pressed.
    assign burst_ok = bus.burst_pulse & (bus.burst_len != '0);

    // Clock enable: halted states only pass a registered step, running states
    // stop on a breakpoint unless it is being stepped over.
    always_comb begin
        cpu_en = 1'b0;
        if (halted) begin
            cpu_en = step_q;
        end else begin
            cpu_en = ~bp_match | skip_q;
        end
    end

    // Next-state: run_pulse beats burst_pulse beats step_pulse; losers are dropped.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        skip_d  = skip_q;
        step_d  = 1'b0;
        if (cpu_en) begin
            skip_d = 1'b0;
        end
        unique case (state_q)
            StPause, StBpHalt: begin
                if (bus.run_pulse) begin
                    state_d = StRun;
                    skip_d  = (state_q == StBpHalt);
                end else if (burst_ok) begin
                    state_d = StBurst;
                    rem_d   = bus.burst_len;
                    skip_d  = (state_q == StBpHalt);
                end else begin
                    step_d = bus.step_pulse;
                end
            end
            StRun: begin
                if (bus.run_pulse) begin
                    state_d = StPause;
                end else if (bp_match && !skip_q) begin
                    state_d = StBpHalt;
                end
            end
            StBurst: begin
                if (bus.run_pulse) begin
                    state_d = StPause;
                    rem_d   = '0;
                end else if (bp_match && !skip_q) begin
                    state_d = StBpHalt;
                    rem_d   = '0;
                end else if (cpu_en) begin
                    if (rem_q == BURST_W'(1)) begin
                        state_d = StPause;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - BURST_W'(1);
                    end
                end
            end
            default: begin
                state_d = StPause;
                rem_d   = '0;
            end
        endcase
    end

    // Retired-cycle counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (cpu_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StPause;
            step_q  <= 1'b0;
            rem_q   <= '0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cpu_en   = cpu_en;
    assign bus.state    = state_q;
    assign bus.bp_hit   = (state_q == StBpHalt);
    assign bus.step_cnt = cnt_q;

    // Remaining-step count only lives while bursting.
    a_rem_burst_only: assert property (@(posedge clk) disable iff (!rstn)
        (state_q != StBurst) |-> (rem_q == '0));
    a_rem_nonzero: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == StBurst) |-> (rem_q != '0));
    // Skip is always consumed by the first running cycle.
    a_skip_running: assert property (@(posedge clk) disable iff (!rstn)
        skip_q |-> ((state_q == StRun) || (state_q == StBurst)));

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios followed by random button traffic,
// all compared against a behavioural model of the stepping rules.
module tb_cpu_step_ctrl;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned PC_W    = 32;
    localparam int CNT_MOD = 1 << CNT_W;

    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_BURST = 2;
    localparam int M_HALT  = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cpu_step_ctrl_if #(.CNT_W(CNT_W), .BURST_W(BURST_W), .PC_W(PC_W)) bus ();

    cpu_step_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W), .PC_W(PC_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: mode, pending single step, instructions left in a burst,
    // breakpoint-skip flag and the retired-instruction count.
    int m_mode;
    bit m_step;
    int m_rem;
    bit m_skip;
    int m_cnt;
    bit last_en;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_PAUSE;
        m_step = 1'b0;
        m_rem  = 0;
        m_skip = 1'b0;
        m_cnt  = 0;
    endfunction

    function automatic bit model_en();
        bit bpm;
        bpm = bus.bp_en && (bus.pc == bus.bp_addr);
        if (m_mode == M_PAUSE || m_mode == M_HALT) return m_step;
        return !bpm || m_skip;
    endfunction

    function automatic void model_update(input bit r, input bit b, input bit s, input int len,
                                         input bit clr, input bit en);
        bit bpm;
        bit was_halt;
        bpm      = bus.bp_en && (bus.pc == bus.bp_addr);
        was_halt = (m_mode == M_HALT);
        m_step   = 1'b0;
        if (r) begin
            if (m_mode == M_PAUSE || m_mode == M_HALT) begin
                m_mode = M_RUN;
                m_skip = was_halt;
            end else begin
                m_mode = M_PAUSE;
                m_rem  = 0;
                m_skip = 1'b0;
            end
        end else if (m_mode == M_PAUSE || m_mode == M_HALT) begin
            if (b && len != 0) begin
                m_mode = M_BURST;
                m_rem  = len;
                m_skip = was_halt;
            end else begin
                m_step = s;
            end
        end else if (bpm && !m_skip) begin
            m_mode = M_HALT;
            m_rem  = 0;
        end else if (en) begin
            m_skip = 1'b0;
            if (m_mode == M_BURST) begin
                m_rem--;
                if (m_rem == 0) m_mode = M_PAUSE;
            end
        end
        if (clr) m_cnt = 0;
        else if (en) m_cnt = (m_cnt + 1) % CNT_MOD;
    endfunction

    // One clock cycle: drive pulses at the falling edge, compare, then let the
    // core advance its PC if it was enabled.
    task automatic tick(input bit r, input bit b, input bit s, input int len, input bit clr);
        bit exp_en;
        bus.run_pulse   = r;
        bus.burst_pulse = b;
        bus.step_pulse  = s;
        bus.burst_len   = BURST_W'(len);
        bus.cnt_clr     = clr;
        #1;
        exp_en  = model_en();
        last_en = bus.cpu_en;
        check("cpu_en", bus.cpu_en, exp_en);
        check("state", bus.state, m_mode);
        check("bp_hit", bus.bp_hit, m_mode == M_HALT);
        check("step_cnt", bus.step_cnt, m_cnt);
        model_update(r, b, s, len, clr, exp_en);
        @(negedge clk);
        bus.run_pulse   = 1'b0;
        bus.burst_pulse = 1'b0;
        bus.step_pulse  = 1'b0;
        bus.cnt_clr     = 1'b0;
        if (exp_en) bus.pc = bus.pc + 32'd4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt0;
        int en_count;
        int prev_cnt;
        bit saw_wrap;
        bit r, b, s, clr;
        int len;

        rstn            = 1'b0;
        bus.run_pulse   = 1'b0;
        bus.burst_pulse = 1'b0;
        bus.step_pulse  = 1'b0;
        bus.burst_len   = '0;
        bus.pc          = '0;
        bus.bp_addr     = '0;
        bus.bp_en       = 1'b0;
        bus.cnt_clr     = 1'b0;
        model_reset();
        #3;
        check("rst_cpu_en", bus.cpu_en, 0);
        check("rst_state", bus.state, 0);
        check("rst_bp_hit", bus.bp_hit, 0);
        check("rst_cnt", bus.step_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle(9);

        // Single step: enable exactly one cycle after the pulse.
        tick(0, 0, 1, 0, 0);
        #1;
        check("step_lat", bus.cpu_en, 1);
        tick(0, 0, 0, 0, 0);
        #1;
        check("step_one", bus.cpu_en, 0);
        check("step_cnt1", bus.step_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0);
            idle(2);
        end
        check("step_cnt4", bus.step_cnt, 4);

        // Burst of five, then an ignored zero-length burst.
        cnt0 = m_cnt;
        tick(0, 1, 0, 5, 0);
        #1;
        check("burst_state", bus.state, 2);
        en_count = 0;
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, 0, 0, 0);
            en_count += int'(last_en);
        end
        check("burst_len5", en_count, 5);
        check("burst_done", bus.state, 0);
        check("burst_cnt", bus.step_cnt, (cnt0 + 5) % CNT_MOD);
        tick(0, 1, 0, 0, 0);
        #1;
        check("burst_zero", bus.state, 0);
        idle(2);

        // Free-run into a breakpoint at 0x40, then resume past it.
        tick(0, 0, 0, 0, 1);
        bus.pc      = 32'h0;
        bus.bp_addr = 32'h40;
        bus.bp_en   = 1'b1;
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 40 && m_mode != M_HALT; i++) tick(0, 0, 0, 0, 0);
        #1;
        check("bp_state", bus.state, 3);
        check("bp_flag", bus.bp_hit, 1);
        check("bp_en_low", bus.cpu_en, 0);
        check("bp_cnt16", bus.step_cnt, 16);
        check("bp_pc", bus.pc, 32'h40);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 10 && bus.pc <= 32'h44; i++) tick(0, 0, 0, 0, 0);
        #1;
        check("bp_resume", bus.state, 1);
        check("bp_past", bus.pc, 32'h48);
        tick(1, 0, 0, 0, 0);
        bus.bp_en = 1'b0;
        idle(2);

        // Burst of ten aborted by run on its 4th cycle; remaining is discarded.
        cnt0 = m_cnt;
        tick(0, 1, 0, 10, 0);
        idle(3);
        tick(1, 0, 0, 0, 0);
        #1;
        check("abort_state", bus.state, 0);
        check("abort_cnt", bus.step_cnt, (cnt0 + 4) % CNT_MOD);
        tick(0, 1, 0, 3, 0);
        idle(6);
        check("reburst_cnt", bus.step_cnt, (cnt0 + 7) % CNT_MOD);

        // Run beats step; clear beats increment; long run wraps the counter.
        tick(1, 0, 1, 0, 0);
        #1;
        check("run_prio", bus.state, 1);
        tick(0, 0, 0, 0, 1);
        #1;
        check("clr_prio", bus.step_cnt, 0);
        saw_wrap = 1'b0;
        prev_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick(0, 0, 0, 0, 0);
            #1;
            if (prev_cnt == CNT_MOD - 1 && bus.step_cnt == 0) saw_wrap = 1'b1;
            prev_cnt = int'(bus.step_cnt);
        end
        check("cnt_wrap", saw_wrap, 1);

        // Asynchronous reset in the middle of a run.
        idle(3);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_en", bus.cpu_en, 0);
        check("arst_state", bus.state, 0);
        check("arst_cnt", bus.step_cnt, 0);
        model_reset();
        @(negedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        idle(4);
        #1;
        check("arst_pause", bus.state, 0);
        check("arst_noglitch", bus.step_cnt, 0);

        // Random button traffic with PC jumps and moving breakpoints.
        bus.bp_addr = 32'h20;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            b   = ($urandom_range(0, 24) == 0);
            s   = ($urandom_range(0, 5) == 0);
            len = int'($urandom_range(0, 12));
            clr = ($urandom_range(0, 59) == 0);
            if (b && len == 0) s = 1'b0;
            if ($urandom_range(0, 29) == 0) bus.pc = 32'(4 * $urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) bus.bp_addr = 32'(4 * $urandom_range(0, 31));
            if ($urandom_range(0, 39) == 0) bus.bp_en = ~bus.bp_en;
            tick(r, b, s, len, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
